multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style control FSM for the multicycle LEGv8 core. It sequences a single shared ALU, register file and unified instruction/data memory over several cycles per instruction. It drives aluop to the ALU control decoder and emits all datapath enables and muxes. It also stalls on a memory-ready handshake and flags illegal opcodes.

## Interface
Parameters:
- OP_W, 11, width of the instruction opcode field (instr[31:21]).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; returns the FSM to FETCH.
- op  in  11  opcode field of the instruction register.
- zero  in  1  ALU zero flag, same cycle.
- memready  in  1  memory has completed the current read/write this cycle.
- pcen  out  1  PC write enable: pcwrite | (branch & zero).
- irwrite  out  1  latch memory read data into the instruction register.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread, memwrite  out  1  memory strobes.
- regwrite  out  1  register file write.
- reg2loc, memtoreg  out  1  register-file mux selects.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2.
- aluop  out  2  00 = add, 01 = pass B, 10 = decode funct.
- pcsrc  out  1  0 = ALU result, 1 = ALUOut.
- instr_done  out  1  one-cycle pulse on the final cycle of each retired instruction.
- illegal  out  1  sticky; set on an unrecognised opcode, cleared only by reset.

## Operation
- States are FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, ALUWB, BRANCH, JUMP (macro only) and HALT.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=0.
  - irwrite and pcwrite are asserted only when memready=1.
  - Stay in FETCH while memready=0; go to DECODE when memready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=00, reg2loc=1 if op is STUR or CBZ. Next state is chosen by op:
  - LDUR 11111000010 or STUR 11111000000 -> MEMADR.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC_R.
  - CBZ (op[10:3]=10110100) -> BRANCH.
  - B (op[10:5]=000101) -> JUMP, only with the macro defined.
  - Anything else -> HALT, and set illegal.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next is MEMRD for LDUR, MEMWR for STUR.
- MEMRD: memread=1, iord=1. Hold until memready=1, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, instr_done=1. Next is FETCH.
- MEMWR: memwrite=1, iord=1. Hold until memready=1; in that cycle pulse instr_done and go to FETCH.
- EXEC_R: alusrca=1, alusrcb=00, aluop=10. Next is ALUWB.
- ALUWB: regwrite=1, memtoreg=0, instr_done=1. Next is FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=1, instr_done=1. Next is FETCH.
  - pcen=zero in this state.
- HALT: all strobes are 0. The FSM stays in HALT until reset.
- Any output not listed for a state is 0.
- The internal branch and pcwrite terms are never visible except through pcen.

## Timing
- State register updates on the rising edge of clk.
- All outputs are combinational decodes of the state (plus memready/zero where stated). No output is registered except illegal.
- While reset=1, every output is 0, including the FETCH strobes, and illegal clears. The first FETCH cycle is the cycle after reset deasserts.
- A reset asserted mid-instruction (e.g. during MEMRD) abandons the instruction. No regwrite or memwrite is issued on the reset cycle.
- Latency with memready tied high:
  - R-type: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ: 3 cycles.
  - B: 3 cycles.
- Each memready=0 cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle of latency.
- memread and memwrite are held constant while waiting for memready.
- instr_done pulses exactly once per retired instruction. It never pulses in HALT.

## Configuration
- UNCOND_BRANCH_EN defined: B decodes to JUMP.
  - JUMP drives pcsrc=1, pcwrite=1 (pcen=1), instr_done=1; next state is FETCH.
  - ALUOut already holds PC + (imm<<2) from DECODE.
- UNCOND_BRANCH_EN undefined: the JUMP state is not compiled, and B is illegal (DECODE -> HALT, illegal=1).

## Structure
- Shared package multicycle_pkg holds:
  - the state enum typedef (4-bit);
  - the opcode constants, reusing the existing ADD/SUB/AND/ORR/LDUR/STUR/CBZ/B macros;
  - the alusrcb encodings and the aluop encodings.
- One natural sub-module, multicycle_opdec: combinational op -> instruction-class decode (mem_ld, mem_st, rtype, cbz, b, bad). It is used by the DECODE next-state logic and by reg2loc.

## Test plan
- Reset held for 2 cycles, then released with memready=1 -> all outputs 0 during reset. Cycle 1: FETCH, memread=1, irwrite=1, pcen=1, alusrcb=01.
- op=10001011000 (ADD), memready=1 -> states FETCH, DECODE, EXEC_R (aluop=10), ALUWB (regwrite=1, instr_done=1). FETCH again on cycle 5.
- op=11111000010 (LDUR) with memready low for 3 cycles in MEMRD -> MEMRD is held 4 cycles with memread=1 and iord=1. MEMWB asserts memtoreg=1 and regwrite=1. Total 8 cycles.
- op=CBZ, zero=1 then zero=0 on a repeat -> BRANCH cycle gives pcen=1, pcsrc=1 in the first case and pcen=0 in the second. Both take 3 cycles.
- op=11111111111 -> DECODE goes to HALT, illegal=1 stays set for 20 cycles, no strobes. Reset clears illegal and restarts in FETCH.
- Reset asserted during MEMWR with memready=0 -> memwrite drops in the reset cycle, and the FSM is in FETCH one cycle after reset deasserts. Repeat with op=B under both macro settings: JUMP with pcen=1 vs HALT with illegal=1.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types for the multicycle LEGv8 controller: FSM states, opcodes, ALU-control encodings.
// Build option UNCOND_BRANCH_EN adds the JUMP state used by B.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_HALT   = 4'd10
`ifdef UNCOND_BRANCH_EN
    , S_JUMP = 4'd9
`endif
  } state_e;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_opdec.sv
// Opcode -> instruction-class decode for the multicycle controller.
// B counts as legal only when UNCOND_BRANCH_EN is defined.
module multicycle_opdec
  import multicycle_pkg::*;
#(
  parameter int OP_W = 11
) (
  input  logic [OP_W-1:0] op,
  output logic            mem_ld,
  output logic            mem_st,
  output logic            rtype,
  output logic            cbz,
  output logic            b,
  output logic            bad
);

  assign mem_ld = (op[10:0] == OP_LDUR);
  assign mem_st = (op[10:0] == OP_STUR);
  assign rtype  = (op[10:0] == OP_ADD) | (op[10:0] == OP_SUB) |
                  (op[10:0] == OP_AND) | (op[10:0] == OP_ORR);
  assign cbz    = (op[10:3] == OP_CBZ_PFX);
  assign b      = (op[10:5] == OP_B_PFX);

`ifdef UNCOND_BRANCH_EN
  assign bad = ~(mem_ld | mem_st | rtype | cbz | b);
`else
  assign bad = ~(mem_ld | mem_st | rtype | cbz);
`endif

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle LEGv8 core; outputs decode the state, gated off during reset.
// Build option UNCOND_BRANCH_EN enables the JUMP state for B.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int OP_W = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            memready,
  output logic            pcen,
  output logic            irwrite,
  output logic            iord,
  output logic            memread,
  output logic            memwrite,
  output logic            regwrite,
  output logic            reg2loc,
  output logic            memtoreg,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      aluop,
  output logic            pcsrc,
  output logic            instr_done,
  output logic            illegal
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   dec_ld, dec_st, dec_r, dec_cbz, dec_b, dec_bad;
  logic   pcwrite, branch;

  multicycle_opdec #(.OP_W(OP_W)) u_opdec (
    .op     (op),
    .mem_ld (dec_ld),
    .mem_st (dec_st),
    .rtype  (dec_r),
    .cbz    (dec_cbz),
    .b      (dec_b),
    .bad    (dec_bad)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  if (memready) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_ld | dec_st)  state_d = S_MEMADR;
        else if (dec_r)       state_d = S_EXEC_R;
        else if (dec_cbz)     state_d = S_BRANCH;
`ifdef UNCOND_BRANCH_EN
        else if (dec_b)       state_d = S_JUMP;
`endif
        else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: state_d = dec_st ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (memready) state_d = S_MEMWB;
      S_MEMWR:  if (memready) state_d = S_FETCH;
      S_EXEC_R: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
`ifdef UNCOND_BRANCH_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset forces every strobe low, even though state_q may already read FETCH.
  always_comb begin
    pcwrite = 1'b0; branch = 1'b0;
    irwrite = 1'b0; iord = 1'b0; memread = 1'b0; memwrite = 1'b0;
    regwrite = 1'b0; reg2loc = 1'b0; memtoreg = 1'b0; alusrca = 1'b0;
    alusrcb = SRCB_REG; aluop = ALUOP_ADD; pcsrc = 1'b0; instr_done = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = SRCB_FOUR;
          irwrite = memready;
          pcwrite = memready;
        end
        S_DECODE: begin
          alusrcb = SRCB_IMM_SH;
          reg2loc = dec_st | dec_cbz;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          memwrite   = 1'b1;
          iord       = 1'b1;
          instr_done = memready;
        end
        S_EXEC_R: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          aluop      = ALUOP_PASSB;
          branch     = 1'b1;
          pcsrc      = 1'b1;
          instr_done = 1'b1;
        end
`ifdef UNCOND_BRANCH_EN
        S_JUMP: begin
          pcsrc      = 1'b1;
          pcwrite    = 1'b1;
          instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign pcen    = pcwrite | (branch & zero);
  assign illegal = illegal_q & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instructions are expanded into per-cycle expected outputs.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] op = '0;
   logic        zero = 1'b0;
   logic        memready = 1'b0;
   logic        pcen, irwrite, iord, memread, memwrite, regwrite, reg2loc, memtoreg;
   logic        alusrca, pcsrc, instr_done, illegal;
   logic [1:0]  alusrcb, aluop;

   always #5 clk = ~clk;

   multicycle_ctrl #(.OP_W(11)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
      .pcen(pcen), .irwrite(irwrite), .iord(iord), .memread(memread), .memwrite(memwrite),
      .regwrite(regwrite), .reg2loc(reg2loc), .memtoreg(memtoreg), .alusrca(alusrca),
      .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .instr_done(instr_done),
      .illegal(illegal)
   );

   typedef struct packed {
      logic       pcen, irwrite, iord, memread, memwrite, regwrite, reg2loc, memtoreg, alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       pcsrc, instr_done, illegal;
   } outs_t;

   typedef struct {
      logic        rst;
      logic [10:0] op;
      logic        mr;
      logic        z;
      outs_t       exp;
      string       tag;
   } step_t;

   step_t       steps[$];
   outs_t       sb[$];
   string       sb_tag[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic        ill_m = 1'b0;
   logic [10:0] cur_op = '0;
   bit          stim_done = 1'b0;
   int          wdog_cycles = 0;
   localparam int WDOG_LIMIT = 50000;

`ifdef UNCOND_BRANCH_EN
   localparam bit B_LEGAL = 1'b1;
`else
   localparam bit B_LEGAL = 1'b0;
`endif

   function automatic outs_t quiet();
      outs_t o = '0;
      o.illegal = ill_m;
      return o;
   endfunction

   function automatic logic rnd();
      return logic'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic rst, input logic mr, input logic z, input outs_t e, input string tag);
      step_t s;
      s.rst = rst; s.op = cur_op; s.mr = mr; s.z = z; s.exp = e; s.tag = tag;
      steps.push_back(s);
   endtask

   task automatic add_reset();
      push(1'b1, rnd(), rnd(), outs_t'(0), "reset");
      ill_m = 1'b0;
   endtask

   // One instruction from FETCH to retirement. wf/wm: memready-low cycles in fetch and in the
   // memory phase; abort replaces the memory-complete cycle with a reset.
   task automatic run_instr(input logic [10:0] o_op, input int wf, input int wm,
                            input logic zb, input bit abort);
      outs_t e;
      bit is_ld, is_st, is_r, is_cbz, is_b;
      cur_op = o_op;
      is_ld  = (o_op == 11'b11111000010);
      is_st  = (o_op == 11'b11111000000);
      is_r   = (o_op == 11'b10001011000) || (o_op == 11'b11001011000) ||
               (o_op == 11'b10001010000) || (o_op == 11'b10101010000);
      is_cbz = (o_op[10:3] == 8'b10110100);
      is_b   = (o_op[10:5] == 6'b000101);

      for (int i = 0; i < wf; i++) begin
         e = quiet(); e.memread = 1; e.alusrcb = 2'b01;
         push(1'b0, 1'b0, rnd(), e, "fetch_wait");
      end
      e = quiet(); e.memread = 1; e.alusrcb = 2'b01; e.irwrite = 1; e.pcen = 1;
      push(1'b0, 1'b1, rnd(), e, "fetch");

      e = quiet(); e.alusrcb = 2'b11; e.reg2loc = is_st | is_cbz;
      push(1'b0, rnd(), rnd(), e, "decode");

      if (is_ld || is_st) begin
         e = quiet(); e.alusrca = 1; e.alusrcb = 2'b10;
         push(1'b0, rnd(), rnd(), e, "memadr");
         for (int i = 0; i < wm; i++) begin
            e = quiet(); e.iord = 1;
            if (is_ld) e.memread = 1; else e.memwrite = 1;
            push(1'b0, 1'b0, rnd(), e, is_ld ? "memrd_wait" : "memwr_wait");
         end
         if (abort) begin
            add_reset();
            return;
         end
         e = quiet(); e.iord = 1;
         if (is_ld) e.memread = 1;
         else begin e.memwrite = 1; e.instr_done = 1; end
         push(1'b0, 1'b1, rnd(), e, is_ld ? "memrd" : "memwr");
         if (is_ld) begin
            e = quiet(); e.regwrite = 1; e.memtoreg = 1; e.instr_done = 1;
            push(1'b0, rnd(), rnd(), e, "memwb");
         end
      end else if (is_r) begin
         e = quiet(); e.alusrca = 1; e.aluop = 2'b10;
         push(1'b0, rnd(), rnd(), e, "exec_r");
         e = quiet(); e.regwrite = 1; e.instr_done = 1;
         push(1'b0, rnd(), rnd(), e, "aluwb");
      end else if (is_cbz) begin
         e = quiet(); e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 1; e.instr_done = 1; e.pcen = zb;
         push(1'b0, rnd(), zb, e, "branch");
      end else if (is_b && B_LEGAL) begin
         e = quiet(); e.pcsrc = 1; e.pcen = 1; e.instr_done = 1;
         push(1'b0, rnd(), rnd(), e, "jump");
      end else begin
         ill_m = 1'b1;
         for (int i = 0; i < 20; i++) push(1'b0, rnd(), rnd(), quiet(), "halt");
         add_reset();
      end
   endtask

   function automatic logic [10:0] rand_op();
      logic [10:0] r;
      case ($urandom_range(0, 7))
         0: r = 11'b11111000010;
         1: r = 11'b11111000000;
         2: r = 11'b10001011000;
         3: r = 11'b11001011000;
         4: r = 11'b10001010000;
         5: r = 11'b10101010000;
         6: r = {8'b10110100, 3'($urandom_range(0, 7))};
         default: r = {6'b000101, 5'($urandom_range(0, 31))};
      endcase
      return r;
   endfunction

   task automatic build();
      logic [10:0] r;
      add_reset();
      add_reset();
      run_instr(11'b10001011000, 0, 0, 1'b0, 1'b0);
      run_instr(11'b11111000010, 0, 3, 1'b0, 1'b0);
      run_instr(11'b10110100101, 0, 0, 1'b1, 1'b0);
      run_instr(11'b10110100101, 0, 0, 1'b0, 1'b0);
      run_instr(11'b11111000000, 2, 1, 1'b0, 1'b0);
      run_instr(11'b11111000000, 0, 2, 1'b0, 1'b1);
      run_instr(11'b00010100000, 0, 0, 1'b0, 1'b0);
      run_instr(11'b11111000000, 1, 1, 1'b0, 1'b0);
      run_instr(11'b00010111111, 0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 150; k++) begin
         r = rand_op();
         run_instr(r, $urandom_range(0, 3), $urandom_range(0, 3), rnd(),
                   ($urandom_range(0, 11) == 0));
      end
      run_instr(11'b11111111111, 1, 0, 1'b0, 1'b0);
      run_instr(11'b10001011000, 0, 0, 1'b0, 1'b0);
   endtask

   outs_t mon_e, mon_a;
   string mon_t;

   always @(negedge clk) begin
      cyc++;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         mon_t = sb_tag.pop_front();
         mon_a = {pcen, irwrite, iord, memread, memwrite, regwrite, reg2loc, memtoreg, alusrca,
                  alusrcb, aluop, pcsrc, instr_done, illegal};
         checks++;
         if (mon_a !== mon_e) begin
            errors++;
            $display("FAIL %s cyc=%0d op=%b got=%b want=%b (pcen,irw,iord,mrd,mwr,rw,r2l,m2r,srca,srcb,aluop,pcsrc,done,ill)",
                     mon_t, cyc, op, mon_a, mon_e);
         end
         if (mon_t == "reset") begin
            checks++;
            if (mon_a !== outs_t'(0)) begin
               errors++;
               $display("FAIL reset-state cyc=%0d outputs not all zero during reset: %b", cyc, mon_a);
            end
         end
      end
   end

   always @(posedge clk) begin
      if (!stim_done) begin
         wdog_cycles++;
         if (wdog_cycles > WDOG_LIMIT) begin
            errors++;
            $display("FAIL timeout: stimulus not finished after %0d cycles", WDOG_LIMIT);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
      end
   end

   step_t s;

   initial begin
      build();
      while (steps.size() > 0) begin
         @(posedge clk);
         #1;
         s        = steps.pop_front();
         reset    = s.rst;
         op       = s.op;
         memready = s.mr;
         zero     = s.z;
         sb.push_back(s.exp);
         sb_tag.push_back(s.tag);
      end
      stim_done = 1'b1;
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
